// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Run/step/breakpoint sequencer between the top-level computer and the CPU core.
//   It gates the CPU clock-enable at instruction boundaries, counts retired
//   instructions and can stop the datapath after any instruction.
//
// Ports
//   clk                   system clock
//   reset                 synchronous, active-high reset
//   run_i                 1-cycle pulse: free-run from IDLE
//   step_i                1-cycle pulse: execute one instruction from IDLE
//   stop_i                1-cycle pulse: stop at the next instruction boundary
//   bp_enable_i           breakpoint compare enable (level)
//   bp_addr_i             breakpoint address
//   cpu_pc_i              CPU program counter
//   cpu_instr_complete_i  high in the final T-state of each instruction
//   cpu_halt_i            CPU executed HLT (level)
//   cpu_clk_en_o          clock-enable to the CPU
//   state_o               00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//   bp_hit_o              1-cycle pulse when a breakpoint stops the CPU
//   instr_count_o         retired instructions since reset
//   count_ovf_o           sticky: instruction counter wrapped
module cpu_run_controller #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_i,
  input  logic                   step_i,
  input  logic                   stop_i,
  input  logic                   bp_enable_i,
  input  logic [ADDR_WIDTH-1:0]  bp_addr_i,
  input  logic [ADDR_WIDTH-1:0]  cpu_pc_i,
  input  logic                   cpu_instr_complete_i,
  input  logic                   cpu_halt_i,
  output logic                   cpu_clk_en_o,
  output logic [1:0]             state_o,
  output logic                   bp_hit_o,
  output logic [COUNT_WIDTH-1:0] instr_count_o,
  output logic                   count_ovf_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StStep   = 2'b10,
    StHalted = 2'b11
  } state_e;

  state_e                 r_state;
  logic                   r_stop_pending;
  logic                   r_bp_hit;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_ovf;

  logic w_boundary;
  logic w_bp_match;

  // Enable is a pure decode of the state register: no input reaches it combinationally.
  assign cpu_clk_en_o = (r_state == StRun) || (r_state == StStep);

  // Only completions the CPU actually clocked through count as boundaries.
  assign w_boundary = cpu_instr_complete_i & cpu_clk_en_o;

  // At the final T-state the PC already names the next, unexecuted instruction,
  // so a match here stops the CPU before bp_addr executes.
  assign w_bp_match = bp_enable_i && (cpu_pc_i == bp_addr_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_stop_pending <= 1'b0;
      r_bp_hit       <= 1'b0;
      r_count        <= '0;
      r_ovf          <= 1'b0;
    end else begin
      r_bp_hit <= 1'b0;

      if (w_boundary) begin
        r_count <= r_count + COUNT_WIDTH'(1);
        if (&r_count) begin
          r_ovf <= 1'b1;
        end
      end

      unique case (r_state)
        StIdle: begin
          r_stop_pending <= 1'b0;
          if (run_i) begin
            r_state <= StRun;
          end else if (step_i) begin
            r_state <= StStep;
          end
        end
        StRun: begin
          if (w_boundary) begin
            // Any pending stop is either honoured here or moot (HALTED/breakpoint).
            r_stop_pending <= 1'b0;
            if (cpu_halt_i) begin
              r_state <= StHalted;
            end else if (w_bp_match) begin
              r_state  <= StIdle;
              r_bp_hit <= 1'b1;
            end else if (r_stop_pending || stop_i) begin
              r_state <= StIdle;
            end
          end else if (stop_i) begin
            r_stop_pending <= 1'b1;
          end
        end
        StStep: begin
          if (w_boundary) begin
            r_state <= cpu_halt_i ? StHalted : StIdle;
          end
        end
        StHalted: begin
          r_state <= StHalted;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign state_o       = r_state;
  assign bp_hit_o      = r_bp_hit;
  assign instr_count_o = r_count;
  assign count_ovf_o   = r_ovf;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller. A mock CPU completes an instruction every 4 enabled
// cycles; its PC advances in the first T-state, so at completion it names the next
// instruction. A second instance with COUNT_WIDTH=4 shares all inputs to exercise wrap.
module tb_cpu_run_controller;

  logic        clk;
  logic        reset;
  logic        run_i;
  logic        step_i;
  logic        stop_i;
  logic        bp_enable_i;
  logic [15:0] bp_addr_i;
  logic [15:0] pc;
  logic [1:0]  t_state;
  logic        instr_complete;
  logic        halt_arm;
  logic        cpu_halt;

  logic        clk_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic [15:0] count;
  logic        ovf;

  logic        clk_en4;
  logic [1:0]  state4;
  logic        bp_hit4;
  logic [3:0]  count4;
  logic        ovf4;

  int n_tests = 0;
  int n_fail  = 0;
  int n_en;
  bit hit_seen;

  cpu_run_controller #(.ADDR_WIDTH(16), .COUNT_WIDTH(16)) u_dut (
    .clk                  (clk),
    .reset                (reset),
    .run_i                (run_i),
    .step_i               (step_i),
    .stop_i               (stop_i),
    .bp_enable_i          (bp_enable_i),
    .bp_addr_i            (bp_addr_i),
    .cpu_pc_i             (pc),
    .cpu_instr_complete_i (instr_complete),
    .cpu_halt_i           (cpu_halt),
    .cpu_clk_en_o         (clk_en),
    .state_o              (state),
    .bp_hit_o             (bp_hit),
    .instr_count_o        (count),
    .count_ovf_o          (ovf)
  );

  cpu_run_controller #(.ADDR_WIDTH(16), .COUNT_WIDTH(4)) u_dut4 (
    .clk                  (clk),
    .reset                (reset),
    .run_i                (run_i),
    .step_i               (step_i),
    .stop_i               (stop_i),
    .bp_enable_i          (bp_enable_i),
    .bp_addr_i            (bp_addr_i),
    .cpu_pc_i             (pc),
    .cpu_instr_complete_i (instr_complete),
    .cpu_halt_i           (cpu_halt),
    .cpu_clk_en_o         (clk_en4),
    .state_o              (state4),
    .bp_hit_o             (bp_hit4),
    .instr_count_o        (count4),
    .count_ovf_o          (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mock CPU
  assign instr_complete = clk_en && (t_state == 2'd3);
  assign cpu_halt       = halt_arm && (pc == 16'd3);

  always @(posedge clk) begin
    if (reset) begin
      t_state <= 2'd0;
      pc      <= 16'd0;
    end else if (clk_en) begin
      if (t_state == 2'd0) pc <= pc + 16'd1;
      t_state <= t_state + 2'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_run();
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
  endtask

  task automatic pulse_step();
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  // Ticks until state matches (bounded); records any bp_hit seen on the way.
  task automatic wait_state(input logic [1:0] st, input string tag);
    int n = 0;
    hit_seen = 1'b0;
    while (state != st && n < 200) begin
      tick();
      n++;
      if (bp_hit && state != st) hit_seen = 1'b1;
    end
    check(tag, 32'(state), 32'(st));
  endtask

  task automatic wait_count(input logic [15:0] c, input string tag);
    int n = 0;
    while (count != c && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(count), 32'(c));
  endtask

  initial begin
    reset       = 1'b0;
    run_i       = 1'b0;
    step_i      = 1'b0;
    stop_i      = 1'b0;
    bp_enable_i = 1'b0;
    bp_addr_i   = 16'h0000;
    halt_arm    = 1'b0;
    #2;

    // 1. reset state, three single steps
    do_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      check("step_state", 32'(state), 32'd2);
      n_en = 0;
      while (clk_en && n_en < 20) begin
        n_en++;
        tick();
      end
      check("step_en_cycles", 32'(n_en), 32'd4);
      check("step_back_idle", 32'(state), 32'd0);
    end
    check("step_count", 32'(count), 32'd3);
    check("step_pc", 32'(pc), 32'd3);

    // 2. breakpoint at 0x0005, then step past it with bp compare aimed at the step target
    do_reset();
    bp_enable_i = 1'b1;
    bp_addr_i   = 16'h0005;
    pulse_run();
    check("run_state", 32'(state), 32'd1);
    check("run_clk_en", 32'(clk_en), 32'd1);
    wait_state(2'd0, "bp_stop_state");
    check("bp_hit_on", 32'(bp_hit), 32'd1);
    check("bp_pc", 32'(pc), 32'd5);
    check("bp_count", 32'(count), 32'd5);
    check("bp_clk_en_off", 32'(clk_en), 32'd0);
    tick();
    check("bp_hit_one_cycle", 32'(bp_hit), 32'd0);
    bp_addr_i = 16'h0006;
    pulse_step();
    wait_state(2'd0, "bp_step_state");
    check("bp_step_pc", 32'(pc), 32'd6);
    check("bp_step_count", 32'(count), 32'd6);
    check("bp_step_no_hit", 32'(hit_seen || bp_hit), 32'd0);
    bp_enable_i = 1'b0;

    // 3a. stop mid-instruction finishes the current instruction only
    do_reset();
    pulse_run();
    tick();
    pulse_stop();
    check("stop_pending_still_run", 32'(state), 32'd1);
    wait_state(2'd0, "stop_mid_state");
    check("stop_mid_count", 32'(count), 32'd1);
    check("stop_mid_pc", 32'(pc), 32'd1);

    // 3b. stop on the completing cycle leaves at that same boundary
    do_reset();
    pulse_stop();  // ignored in IDLE
    pulse_run();
    n_en = 0;
    while (!instr_complete && n_en < 20) begin
      n_en++;
      tick();
    end
    pulse_stop();
    check("stop_edge_state", 32'(state), 32'd0);
    check("stop_edge_count", 32'(count), 32'd1);
    // no stale pending stop: a new run passes the first boundary
    pulse_run();
    wait_count(16'd3, "rerun_count");
    check("rerun_still_run", 32'(state), 32'd1);
    pulse_stop();
    wait_state(2'd0, "rerun_stop_state");
    check("rerun_stop_count", 32'(count), 32'd4);

    // 4. halt at the 3rd completion
    do_reset();
    halt_arm = 1'b1;
    pulse_run();
    wait_state(2'd3, "halt_state");
    check("halt_clk_en", 32'(clk_en), 32'd0);
    check("halt_count", 32'(count), 32'd3);
    pulse_run();
    pulse_step();
    tick();
    check("halt_sticky_state", 32'(state), 32'd3);
    check("halt_sticky_en", 32'(clk_en), 32'd0);
    halt_arm = 1'b0;
    do_reset();
    check("halt_reset_state", 32'(state), 32'd0);
    check("halt_reset_count", 32'(count), 32'd0);

    // 5. wrap of the 4-bit counter
    do_reset();
    pulse_run();
    wait_count(16'd15, "wrap_c15");
    check("wrap4_c15", 32'(count4), 32'd15);
    check("wrap4_ovf_c15", 32'(ovf4), 32'd0);
    wait_count(16'd17, "wrap_c17");
    check("wrap4_c17", 32'(count4), 32'd1);
    check("wrap4_ovf", 32'(ovf4), 32'd1);
    check("wrap16_ovf", 32'(ovf), 32'd0);
    check("wrap4_state", 32'(state4), 32'd1);
    check("wrap4_en", 32'(clk_en4), 32'd1);
    pulse_stop();
    wait_state(2'd0, "wrap_stop_state");
    check("wrap4_ovf_sticky", 32'(ovf4), 32'd1);
    check("wrap4_no_hit", 32'(bp_hit4), 32'd0);

    // 6. reset mid-step, then simultaneous run+step
    do_reset();
    bp_enable_i = 1'b1;
    bp_addr_i   = 16'h0001;
    pulse_step();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_en", 32'(clk_en), 32'd0);
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_hit", 32'(bp_hit), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    bp_enable_i = 1'b0;
    run_i  = 1'b1;
    step_i = 1'b1;
    tick();
    run_i  = 1'b0;
    step_i = 1'b0;
    check("run_wins_state", 32'(state), 32'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
